cpu_trace_capture: RTL

Captures a retirement trace of the single-cycle MIPS core and streams it out as framed bytes. Each cycle with a commit, the block records PC, instruction, and write-back information into a small FIFO. A serializer then emits the records over a valid/ready byte stream, normally toward a UART transmitter. It sits beside `top` on the CPU debug bus and is the on-chip consumer of the signals the simulation fixture watches.

---
 rtl/trace_pkg.sv | 41 ++++
 rtl/cpu_trace_capture_if.sv | 27 ++
 rtl/trace_fifo.sv | 49 ++++
 rtl/cpu_trace_capture.sv | 95 +++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, state encoding and record packer for the trace capture
package trace_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         RECORD_BYTES = 14;
  localparam int         RECORD_W     = 104;

  localparam int FLAG_REGWRITE = 7;
  localparam int FLAG_MEMWRITE = 6;
  localparam int FLAG_RD_MSB   = 5;
  localparam int FLAG_RD_LSB   = 1;
  localparam int FLAG_LOST     = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Record layout is {flags, PC, instruction, data}; the sync byte is added by the serializer.
  function automatic logic [RECORD_W-1:0] pack_record(
    input logic        reg_write,
    input logic        mem_write,
    input logic [4:0]  rd,
    input logic        lost,
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [31:0] wdata,
    input logic [31:0] sdata
  );
    logic [7:0]  flags;
    logic [31:0] data;
    flags                          = '0;
    flags[FLAG_REGWRITE]           = reg_write;
    flags[FLAG_MEMWRITE]           = mem_write;
    flags[FLAG_RD_MSB:FLAG_RD_LSB] = reg_write ? rd : 5'd0;
    flags[FLAG_LOST]               = lost;
    data = reg_write ? wdata : (mem_write ? sdata : 32'd0);
    return {flags, pc, instr, data};
  endfunction

endpackage

// File: rtl/cpu_trace_capture_if.sv
// rtl/cpu_trace_capture_if.sv - commit-side capture signals and outgoing byte stream
interface cpu_trace_capture_if;
  logic        en;
  logic        commit;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        RegWrite;
  logic [4:0]  r3_addr_mux;
  logic [31:0] reg_datain;
  logic        MemWrite;
  logic [31:0] r2_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output en, commit, PC, instruction, RegWrite, r3_addr_mux, reg_datain, MemWrite, r2_dout,
    output tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  en, commit, PC, instruction, RegWrite, r3_addr_mux, reg_datain, MemWrite, r2_dout,
    input  tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous record FIFO; a push into a full FIFO succeeds when a pop happens the same cycle
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 104
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/cpu_trace_capture.sv
// rtl/cpu_trace_capture.sv - packs retirement records into a FIFO and streams them as 14-byte frames
module cpu_trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  cpu_trace_capture_if.slave     bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            dropped_cnt,
  output logic                   busy
);
  localparam logic [3:0] LAST_IDX = 4'(RECORD_BYTES - 1);

  ser_state_t          state;
  logic [3:0]          idx;
  logic [RECORD_W-1:0] shreg;
  logic [RECORD_W-1:0] fifo_din;
  logic [RECORD_W-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                lost;
  logic                push;
  logic                pop;
  logic                accept;

  assign push   = bus.en & bus.commit;
  assign pop    = (state == ST_IDLE) & ~fifo_empty;
  assign accept = push & (~fifo_full | pop);
  assign busy   = (state == ST_SEND);

  assign fifo_din = pack_record(bus.RegWrite, bus.MemWrite, bus.r3_addr_mux, lost,
                                bus.PC, bus.instruction, bus.reg_datain, bus.r2_dout);

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(RECORD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost        <= 1'b0;
      dropped_cnt <= '0;
    end else if (accept) begin
      lost <= 1'b0;
    end else if (push) begin
      lost <= 1'b1;
      if (dropped_cnt != 16'hFFFF) dropped_cnt <= dropped_cnt + 16'd1;
    end
  end

  // The shift register holds the not-yet-sent record bytes; tx_data is the byte on the wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      shreg        <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg        <= fifo_dout;
            idx          <= '0;
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= SYNC_BYTE;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.tx_ready) begin
            if (idx == LAST_IDX) begin
              bus.tx_valid <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              idx         <= idx + 4'd1;
              bus.tx_data <= shreg[RECORD_W-1 -: 8];
              shreg       <= {shreg[RECORD_W-9:0], 8'h00};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
